mul_issue: RTL and testbench
============================

# mul_issue

Execute-stage initiator for the shared radix-4 Booth multiplier. It accepts an RV64M multiply op (MUL/MULH/MULHSU/MULHU/MULW) from the EX pipeline and translates it into the multiplier's request encoding. It drives a one-cycle request pulse, waits for the one-cycle result pulse, selects and sign-extends the result, and holds it until the next stage takes it. It stalls EX for the whole operation and handles flushes, including draining a multiplier that is still busy.

## Interface
- No parameters; datapath XLEN fixed at 64.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ex_valid  in  1  EX holds an op for this block. Held stable while ex_stall=1.
- ex_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU. Values 1xx are ignored (no request, no stall).
- ex_word  in  1  MULW; forces MUL selection regardless of ex_op[1:0].
- ex_src1, ex_src2  in  64  rs1 / rs2 values.
- ex_flush  in  1  kill the current op.
- ex_out_ready  in  1  next stage accepts the result.
- ex_stall  out  1  freeze EX.
- ex_result_valid  out  1  ex_result valid.
- ex_result  out  64  final rd value.
- mul_in_valid  out  1  request pulse to the multiplier.
- mul_flush  out  1  cancel pulse to the multiplier.
- mul_mulw  out  1  copy of the latched ex_word.
- mul_signed  out  2  bit1 = multiplicand signed, bit0 = multiplier signed.
- mul_multiplicand, mul_multiplier  out  64  operands.
- mul_out_ready  in  1  multiplier idle and able to accept.
- mul_out_valid  in  1  one-cycle result strobe.
- mul_result_hi, mul_result_lo  in  64  128-bit product halves, valid only with mul_out_valid.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE → REQ: when ex_valid & !ex_op[2] & !ex_flush & mul_out_ready. On this transition, latch the op, word flag and operands.
- Operand and sign mapping:
  - multiplicand = rs1, multiplier = rs2.
  - mul_signed: MUL = 11, MULH = 11, MULHSU = 10, MULHU = 00.
  - MULW: operands are sext(src[31:0]) and mul_signed = 11.
- REQ:
  - mul_in_valid = 1 for exactly one cycle, with operands taken from the latch.
  - Go to WAIT. If mul_out_ready = 0, stay in REQ with mul_in_valid held.
  - mul_in_valid is never high in any state other than REQ.
- WAIT: on mul_out_valid, capture the result register and go to DONE. Result selection:
  - MUL: lo.
  - MULH / MULHSU / MULHU: hi.
  - MULW: sext(lo[31:0]).
- DONE:
  - ex_result_valid = 1; ex_result comes from the register.
  - If ex_out_ready, go to IDLE. Otherwise hold the state, with ex_result stable.
- ex_stall = ex_valid & !ex_op[2] & !ex_flush & !(DONE & ex_out_ready). It is combinational and forced to 0 while reset is high.
- Flush:
  - From IDLE or DONE: go to IDLE. The DONE result is dropped and ex_result_valid drops the next cycle.
  - From REQ or WAIT: mul_flush = 1 for one cycle, then go to DRAIN. No request is issued in the flush cycle.
  - DRAIN: suppress ex_result_valid. Go to IDLE on the first cycle with mul_out_ready = 1; any mul_out_valid seen in DRAIN or in that cycle is discarded.
- Simultaneous mul_out_valid and ex_flush in WAIT: flush wins, the result is discarded, and the next state is IDLE (the multiplier is already ready).

## Timing
- Reset values (registered, next edge after reset): state IDLE; all outputs 0, including mul_in_valid, mul_flush, ex_result_valid and ex_result.
- Latency:
  - Accept at cycle 0 (IDLE), REQ at cycle 1, multiplier accepts at the edge ending cycle 1.
  - With L = cycles from multiplier accept to mul_out_valid, ex_result_valid rises at cycle 2+L.
  - For the 33-cycle multiplier this is cycle 35.
- Throughput: one op per 3+L cycles. At least one IDLE cycle separates back-to-back ops.
- Reset mid-operation (any state): IDLE at the next edge with all outputs 0. The multiplier is reset by the same signal.

## Test plan
- MUL, rs1 = 3, rs2 = 0xFFFF_FFFF_FFFF_FFFB → mul_signed = 11, mul_in_valid high exactly 1 cycle, ex_result = 0xFFFF_FFFF_FFFF_FFF1 at cycle 2+L, ex_stall low in that cycle.
- MULHU, rs1 = rs2 = 0xFFFF_FFFF_FFFF_FFFF → mul_signed = 00, ex_result = 0xFFFF_FFFF_FFFF_FFFE.
- MULHSU, rs1 = 0xFFFF_FFFF_FFFF_FFFF, rs2 = 2 → mul_signed = 10, mul_multiplicand = rs1, ex_result = 0xFFFF_FFFF_FFFF_FFFF.
- MULW (ex_word = 1, ex_op = 000), rs1 = 0xFFFF_FFFF_7FFF_FFFF, rs2 = 2 → mul_multiplicand = 0x0000_0000_7FFF_FFFF, mul_mulw = 1, ex_result = 0xFFFF_FFFF_FFFF_FFFE.
- Flush in WAIT 10 cycles after the request, with the multiplier still busy → mul_flush 1-cycle pulse, state DRAIN, a later stale mul_out_valid produces no ex_result_valid, and the next op's mul_in_valid comes only after mul_out_ready = 1.
- ex_out_ready = 0 for 5 cycles in DONE → ex_result_valid and ex_result held, no mul_in_valid. Separately, reset asserted in WAIT → all outputs 0 next cycle and ex_result_valid never rises.

Source files
------------

// File: rtl/mul_issue.sv
// mul_issue: execute-stage initiator for the shared radix-4 Booth multiplier.
//
// Takes an RV64M multiply op (MUL/MULH/MULHSU/MULHU/MULW) from EX and turns it
// into a single multiplier request. It then waits for the result strobe,
// selects and sign-extends the rd value, and holds it until the next stage
// accepts it. EX is stalled for the whole operation. A flush while the
// multiplier is busy sends a cancel pulse and then drains until the multiplier
// reports idle again.
//
// Ports
//   clock, reset          clock; synchronous active-high reset
//   ex_valid/op/word      op from EX (ex_op = funct3, 1xx ignored; ex_word = MULW)
//   ex_src1, ex_src2      rs1 / rs2 operands
//   ex_flush              kill the current op
//   ex_out_ready          next stage takes ex_result this cycle
//   ex_stall              freeze EX (combinational)
//   ex_result_valid       ex_result holds a finished rd value
//   ex_result             rd value
//   mul_in_valid          one-cycle request pulse to the multiplier
//   mul_flush             one-cycle cancel pulse to the multiplier
//   mul_mulw, mul_signed  request mode (mul_signed[1] = multiplicand signed,
//                         mul_signed[0] = multiplier signed)
//   mul_multiplicand/_multiplier  request operands
//   mul_out_ready         multiplier idle
//   mul_out_valid         one-cycle result strobe with mul_result_hi/lo
//   debug_state           current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE, 4 DRAIN)
//
// Handshakes: a request is transferred on an edge where mul_in_valid and
// mul_out_ready are both high. A result is transferred on an edge where
// ex_result_valid and ex_out_ready are both high. mul_out_valid is a strobe
// with no back-pressure.

module mul_issue (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic        ex_word,
  input  logic [63:0] ex_src1,
  input  logic [63:0] ex_src2,
  input  logic        ex_flush,
  input  logic        ex_out_ready,
  output logic        ex_stall,
  output logic        ex_result_valid,
  output logic [63:0] ex_result,
  output logic        mul_in_valid,
  output logic        mul_flush,
  output logic        mul_mulw,
  output logic [1:0]  mul_signed,
  output logic [63:0] mul_multiplicand,
  output logic [63:0] mul_multiplier,
  input  logic        mul_out_ready,
  input  logic        mul_out_valid,
  input  logic [63:0] mul_result_hi,
  input  logic [63:0] mul_result_lo,
  output logic [2:0]  debug_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic        is_mul_op;
  logic        accept;
  logic [1:0]  sign_sel;
  logic [63:0] opa_sel;
  logic [63:0] opb_sel;
  logic [63:0] result_sel;

  assign is_mul_op = ex_valid & ~ex_op[2] & ~ex_flush;
  assign accept    = is_mul_op & mul_out_ready;

  // The stall drops in the DONE cycle the result is taken, so EX advances
  // on the same edge that retires the op.
  assign ex_stall = ~reset & is_mul_op &
                    ~((state == S_DONE) & ex_out_ready);

  assign debug_state = state;

  // Request encoding for the op currently offered by EX.
  always_comb begin
    sign_sel = 2'b11;
    opa_sel  = ex_src1;
    opb_sel  = ex_src2;
    if (ex_word) begin
      opa_sel = {{32{ex_src1[31]}}, ex_src1[31:0]};
      opb_sel = {{32{ex_src2[31]}}, ex_src2[31:0]};
    end else begin
      case (ex_op[1:0])
        2'b10:   sign_sel = 2'b10;
        2'b11:   sign_sel = 2'b00;
        default: sign_sel = 2'b11;
      endcase
    end
  end

  // rd selection from the 128-bit product, using the latched op.
  always_comb begin
    result_sel = mul_result_hi;
    if (mul_mulw)
      result_sel = {{32{mul_result_lo[31]}}, mul_result_lo[31:0]};
    else if (op_q == 2'b00)
      result_sel = mul_result_lo;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      op_q             <= 2'b00;
      mul_in_valid     <= 1'b0;
      mul_flush        <= 1'b0;
      mul_mulw         <= 1'b0;
      mul_signed       <= 2'b00;
      mul_multiplicand <= 64'd0;
      mul_multiplier   <= 64'd0;
      ex_result_valid  <= 1'b0;
      ex_result        <= 64'd0;
    end else begin
      mul_flush <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q             <= ex_op[1:0];
            mul_mulw         <= ex_word;
            mul_signed       <= sign_sel;
            mul_multiplicand <= opa_sel;
            mul_multiplier   <= opb_sel;
            mul_in_valid     <= 1'b1;
            state            <= S_REQ;
          end
        end
        S_REQ: begin
          if (ex_flush) begin
            mul_in_valid <= 1'b0;
            mul_flush    <= 1'b1;
            state        <= S_DRAIN;
          end else if (mul_out_ready) begin
            mul_in_valid <= 1'b0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ex_flush) begin
            // A result arriving with the flush means the multiplier is
            // already idle: nothing to cancel or drain.
            if (mul_out_valid) begin
              state <= S_IDLE;
            end else begin
              mul_flush <= 1'b1;
              state     <= S_DRAIN;
            end
          end else if (mul_out_valid) begin
            ex_result       <= result_sel;
            ex_result_valid <= 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          if (ex_flush || ex_out_ready) begin
            ex_result_valid <= 1'b0;
            state           <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // Any stale result strobe seen here is ignored.
          if (mul_out_ready)
            state <= S_IDLE;
        end
        default: begin
          mul_in_valid    <= 1'b0;
          ex_result_valid <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue.sv
// Directed testbench for mul_issue. The bench plays the multiplier by hand:
// it drives mul_out_ready / mul_out_valid and supplies hand-computed 128-bit
// products. Inputs change and outputs are sampled on the falling edge.

module tb_mul_issue;

  logic        clock;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic        ex_word;
  logic [63:0] ex_src1;
  logic [63:0] ex_src2;
  logic        ex_flush;
  logic        ex_out_ready;
  logic        ex_stall;
  logic        ex_result_valid;
  logic [63:0] ex_result;
  logic        mul_in_valid;
  logic        mul_flush;
  logic        mul_mulw;
  logic [1:0]  mul_signed;
  logic [63:0] mul_multiplicand;
  logic [63:0] mul_multiplier;
  logic        mul_out_ready;
  logic        mul_out_valid;
  logic [63:0] mul_result_hi;
  logic [63:0] mul_result_lo;
  logic [2:0]  debug_state;

  int total;
  int bad;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  mul_issue dut (
    .clock            (clock),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_op            (ex_op),
    .ex_word          (ex_word),
    .ex_src1          (ex_src1),
    .ex_src2          (ex_src2),
    .ex_flush         (ex_flush),
    .ex_out_ready     (ex_out_ready),
    .ex_stall         (ex_stall),
    .ex_result_valid  (ex_result_valid),
    .ex_result        (ex_result),
    .mul_in_valid     (mul_in_valid),
    .mul_flush        (mul_flush),
    .mul_mulw         (mul_mulw),
    .mul_signed       (mul_signed),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_out_ready    (mul_out_ready),
    .mul_out_valid    (mul_out_valid),
    .mul_result_hi    (mul_result_hi),
    .mul_result_lo    (mul_result_lo),
    .debug_state      (debug_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_valid"}, 64'(mul_in_valid), 64'd0);
    chk({tag, "_flush"},    64'(mul_flush), 64'd0);
    chk({tag, "_rvalid"},   64'(ex_result_valid), 64'd0);
    chk({tag, "_result"},   ex_result, 64'd0);
    chk({tag, "_signed"},   64'(mul_signed), 64'd0);
    chk({tag, "_mcand"},    mul_multiplicand, 64'd0);
    chk({tag, "_mplier"},   mul_multiplier, 64'd0);
    chk({tag, "_mulw"},     64'(mul_mulw), 64'd0);
    chk({tag, "_state"},    64'(debug_state), 64'(ST_IDLE));
  endtask

  // Drive one op from IDLE to retirement. lat = cycles from multiplier
  // accept to mul_out_valid (>= 1); hold = DONE cycles with ex_out_ready low.
  task automatic do_op(input string tag, input logic [2:0] op, input logic word,
                       input logic [63:0] s1, input logic [63:0] s2,
                       input logic [1:0] esig, input logic [63:0] emc,
                       input logic [63:0] emp, input logic [63:0] hi,
                       input logic [63:0] lo, input logic [63:0] eres,
                       input int lat, input int hold);
    // cycle 0: offer op in IDLE
    ex_valid = 1'b1; ex_op = op; ex_word = word; ex_src1 = s1; ex_src2 = s2;
    ex_flush = 1'b0; ex_out_ready = 1'b1; mul_out_ready = 1'b1; mul_out_valid = 1'b0;
    #1;
    chk({tag, "_stall_c0"}, 64'(ex_stall), 64'd1);
    tick();
    // cycle 1: REQ, multiplier accepts at the end of this cycle
    chk({tag, "_req_valid"}, 64'(mul_in_valid), 64'd1);
    chk({tag, "_req_state"}, 64'(debug_state), 64'(ST_REQ));
    chk({tag, "_signed"}, 64'(mul_signed), 64'(esig));
    chk({tag, "_mcand"}, mul_multiplicand, emc);
    chk({tag, "_mplier"}, mul_multiplier, emp);
    chk({tag, "_mulw"}, 64'(mul_mulw), 64'(word));
    tick();
    // cycles 2 .. 1+lat: multiplier busy, result on the last one
    for (int i = 2; i <= 1 + lat; i++) begin
      chk({tag, "_busy_inv"}, 64'(mul_in_valid), 64'd0);
      chk({tag, "_busy_rv"}, 64'(ex_result_valid), 64'd0);
      chk({tag, "_busy_stall"}, 64'(ex_stall), 64'd1);
      if (i == 1 + lat) begin
        mul_out_valid = 1'b1; mul_result_hi = hi; mul_result_lo = lo;
        mul_out_ready = 1'b1;
      end else begin
        mul_out_ready = 1'b0;
      end
      tick();
    end
    mul_out_valid = 1'b0; mul_result_hi = 64'hDEAD_BEEF_0BAD_F00D;
    mul_result_lo = 64'h0123_4567_89AB_CDEF;
    // cycle 2+lat: DONE
    ex_out_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      #1;
      chk({tag, "_hold_rv"}, 64'(ex_result_valid), 64'd1);
      chk({tag, "_hold_res"}, ex_result, eres);
      chk({tag, "_hold_stall"}, 64'(ex_stall), 64'd1);
      chk({tag, "_hold_inv"}, 64'(mul_in_valid), 64'd0);
      tick();
    end
    ex_out_ready = 1'b1;
    #1;
    chk({tag, "_done_rv"}, 64'(ex_result_valid), 64'd1);
    chk({tag, "_done_state"}, 64'(debug_state), 64'(ST_DONE));
    chk({tag, "_result"}, ex_result, eres);
    chk({tag, "_done_stall"}, 64'(ex_stall), 64'd0);
    tick();
    ex_valid = 1'b0;
    chk({tag, "_after_rv"}, 64'(ex_result_valid), 64'd0);
    chk({tag, "_after_state"}, 64'(debug_state), 64'(ST_IDLE));
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    ex_valid = 1'b1; ex_op = 3'b000; ex_word = 1'b0; ex_src1 = 64'd9; ex_src2 = 64'd9;
    ex_flush = 1'b0; ex_out_ready = 1'b1;
    mul_out_ready = 1'b1; mul_out_valid = 1'b0; mul_result_hi = 64'd0; mul_result_lo = 64'd0;
    tick();
    #1;
    chk("rst_stall", 64'(ex_stall), 64'd0);
    tick();
    chk_all_zero("rst");
    ex_valid = 1'b0;
    reset = 1'b0;
    tick();

    // MUL 3 * -5 = -15, L = 3, result taken at once
    do_op("mul", 3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 2'b11,
          64'd3, 64'hFFFF_FFFF_FFFF_FFFB, ONES, 64'hFFFF_FFFF_FFFF_FFF1,
          64'hFFFF_FFFF_FFFF_FFF1, 3, 0);
    tick();

    // MULHU (2^64-1)^2 = 2^128 - 2^65 + 1
    do_op("mulhu", 3'b011, 1'b0, ONES, ONES, 2'b00, ONES, ONES,
          64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);
    tick();

    // MULHSU -1 * 2 (unsigned) = -2
    do_op("mulhsu", 3'b010, 1'b0, ONES, 64'd2, 2'b10, ONES, 64'd2,
          ONES, 64'hFFFF_FFFF_FFFF_FFFE, ONES, 4, 0);
    tick();

    // MULH (-2^63)^2 = 2^126, result held 5 cycles in DONE
    do_op("mulh", 3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000, 64'd0, 64'h4000_0000_0000_0000, 2, 5);
    tick();

    // MULW: 0x7FFFFFFF * 2 = 0xFFFFFFFE, sign-extended from bit 31
    do_op("mulw", 3'b000, 1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 64'd2, 2'b11,
          64'h0000_0000_7FFF_FFFF, 64'd2, 64'd0, 64'h0000_0000_FFFF_FFFE,
          64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
    tick();

    // ignored op (funct3 1xx): no stall, no request
    ex_valid = 1'b1; ex_op = 3'b100; ex_word = 1'b0;
    #1;
    chk("ign_stall", 64'(ex_stall), 64'd0);
    tick();
    chk("ign_inv", 64'(mul_in_valid), 64'd0);
    chk("ign_state", 64'(debug_state), 64'(ST_IDLE));
    ex_valid = 1'b0;
    tick();

    // flush in WAIT 10 cycles after the request, multiplier still busy
    ex_valid = 1'b1; ex_op = 3'b000; ex_word = 1'b0; ex_src1 = 64'd5; ex_src2 = 64'd7;
    mul_out_ready = 1'b1;
    tick();                                   // cycle 1: REQ
    chk("fl_req", 64'(mul_in_valid), 64'd1);
    tick();                                   // cycle 2: WAIT
    mul_out_ready = 1'b0;
    for (int i = 2; i < 11; i++) tick();      // now cycle 11
    chk("fl_wait_state", 64'(debug_state), 64'(ST_WAIT));
    ex_flush = 1'b1;
    #1;
    chk("fl_stall", 64'(ex_stall), 64'd0);
    tick();                                   // cycle 12
    chk("fl_pulse", 64'(mul_flush), 64'd1);
    chk("fl_drain", 64'(debug_state), 64'(ST_DRAIN));
    chk("fl_inv", 64'(mul_in_valid), 64'd0);
    // next op offered while the multiplier drains
    ex_flush = 1'b0; ex_src1 = 64'd6; ex_src2 = 64'd7;
    tick();                                   // cycle 13
    chk("fl_pulse_end", 64'(mul_flush), 64'd0);
    chk("fl_drain2", 64'(debug_state), 64'(ST_DRAIN));
    mul_out_valid = 1'b1; mul_result_hi = 64'd0; mul_result_lo = 64'd35;
    tick();                                   // cycle 14
    mul_out_valid = 1'b0;
    chk("fl_stale_rv", 64'(ex_result_valid), 64'd0);
    chk("fl_drain3", 64'(debug_state), 64'(ST_DRAIN));
    chk("fl_drain_inv", 64'(mul_in_valid), 64'd0);
    mul_out_ready = 1'b1;
    tick();                                   // cycle 15: back in IDLE
    chk("fl_idle", 64'(debug_state), 64'(ST_IDLE));
    chk("fl_idle_inv", 64'(mul_in_valid), 64'd0);
    chk("fl_idle_rv", 64'(ex_result_valid), 64'd0);
    tick();                                   // cycle 16: new REQ
    chk("fl_next_req", 64'(mul_in_valid), 64'd1);
    chk("fl_next_mcand", mul_multiplicand, 64'd6);
    tick();
    mul_out_valid = 1'b1; mul_result_hi = 64'd0; mul_result_lo = 64'd42;
    tick();
    mul_out_valid = 1'b0;
    chk("fl_next_rv", 64'(ex_result_valid), 64'd1);
    chk("fl_next_res", ex_result, 64'd42);
    ex_valid = 1'b0;
    tick();

    // flush together with the result strobe in WAIT: straight to IDLE
    ex_valid = 1'b1; ex_src1 = 64'd2; ex_src2 = 64'd2;
    tick();                                   // REQ
    tick();                                   // WAIT
    ex_flush = 1'b1; mul_out_valid = 1'b1; mul_result_lo = 64'd4;
    tick();
    ex_flush = 1'b0; mul_out_valid = 1'b0; ex_valid = 1'b0;
    chk("flv_state", 64'(debug_state), 64'(ST_IDLE));
    chk("flv_rv", 64'(ex_result_valid), 64'd0);
    chk("flv_pulse", 64'(mul_flush), 64'd0);
    tick();

    // reset asserted in WAIT
    ex_valid = 1'b1; ex_op = 3'b001; ex_src1 = 64'd11; ex_src2 = 64'd13;
    tick();                                   // REQ
    tick();                                   // WAIT
    mul_out_ready = 1'b0;
    tick();
    chk("rw_state", 64'(debug_state), 64'(ST_WAIT));
    reset = 1'b1;
    #1;
    chk("rw_stall", 64'(ex_stall), 64'd0);
    tick();
    chk_all_zero("rw");
    reset = 1'b0; ex_valid = 1'b0; mul_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw_no_rv", 64'(ex_result_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
